mem_level: RTL and testbench

Memory-access stage of the five-stage MIPS pipeline: it sits directly downstream of the execute stage and upstream of write-back. It consumes the execute stage's MEM-side pipeline registers and drives a word-addressed data-memory port with a req/ready handshake. It performs byte-lane steering for stores and extension for loads. It registers the results into the WB pipeline registers and freezes the upstream pipeline while the memory is not ready.

---
 rtl/mem_level_pkg.sv | 64 ++++++
 rtl/mem_lane.sv | 43 ++++
 rtl/mem_level.sv | 159 +++++++++++++++
 tb/tb_mem_level.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_level_pkg.sv
// Shared definitions for the memory-access stage:
// instruction codes, the IC classifier, FSM states.
package mem_level_pkg;

  localparam int WIDTH_INSTR = 6;
  localparam int WIDTH_T     = 2;

  typedef enum logic [WIDTH_INSTR-1:0] {
    I_NOP,
    I_ADDU,
    I_LB,
    I_LBU,
    I_LH,
    I_LHU,
    I_LW,
    I_SB,
    I_SH,
    I_SW
  } instr_e;

  typedef enum logic [1:0] {
    FUNC_NONE,
    MEM_READ,
    MEM_WRITE
  } func_e;

  typedef enum logic {
    IDLE,
    WAIT
  } mem_state_e;

  function automatic func_e ic_func(
    input logic [WIDTH_INSTR-1:0] ic
  );
    func_e f;
    f = FUNC_NONE;
    unique case (1'b1)
      ic == I_LB,
      ic == I_LBU,
      ic == I_LH,
      ic == I_LHU,
      ic == I_LW: f = MEM_READ;
      ic == I_SB,
      ic == I_SH,
      ic == I_SW: f = MEM_WRITE;
      default: f = FUNC_NONE;
    endcase
    return f;
  endfunction

  function automatic logic is_half(
    input logic [WIDTH_INSTR-1:0] ic
  );
    return ic == I_LH || ic == I_LHU ||
           ic == I_SH;
  endfunction

  function automatic logic is_word(
    input logic [WIDTH_INSTR-1:0] ic
  );
    return ic == I_LW || ic == I_SW;
  endfunction

endpackage

// File: rtl/mem_lane.sv
// Byte-lane steering for stores and lane select plus extension for loads.
// Ports: a (addr[1:0]), op, st_data, rdata -> be, wdata, ldata.
module mem_lane
  import mem_level_pkg::*;
(
  input  logic [1:0]             a,
  input  logic [WIDTH_INSTR-1:0] op,
  input  logic [31:0]            st_data,
  input  logic [31:0]            rdata,
  output logic [3:0]             be,
  output logic [31:0]            wdata,
  output logic [31:0]            ldata
);

  logic [7:0]  rb;
  logic [15:0] rh;

  assign rb = rdata[{a, 3'b000} +: 8];
  // a[0] is dropped: halfword accesses are forced aligned.
  assign rh = a[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    be    = 4'b1111;
    wdata = st_data;
    ldata = rdata;
    unique case (1'b1)
      op == I_SB: begin
        be    = 4'b0001 << a;
        wdata = {4{st_data[7:0]}};
      end
      op == I_SH: begin
        be    = a[1] ? 4'b1100 : 4'b0011;
        wdata = {2{st_data[15:0]}};
      end
      op == I_LB:  ldata = {{24{rb[7]}}, rb};
      op == I_LBU: ldata = {24'd0, rb};
      op == I_LH:  ldata = {{16{rh[15]}}, rh};
      op == I_LHU: ldata = {16'd0, rh};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_level.sv
// MEM stage: data-memory req/ready port, store forwarding, WB registers.
// Ports: MEM-side regs in, dm_* port, MEMBusy stall, WB regs out.
// Optional MEM_ALIGN_CHECK_EN adds exc_AdEL / exc_AdES.
module mem_level
  import mem_level_pkg::*;
#(
  parameter int DM_WAIT_MAX = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH_INSTR-1:0] instr_MEM,
  input  logic [31:0]            PC_MEM,
  input  logic [31:0]            aluOut_MEM,
  input  logic [31:0]            memWriteData_MEM,
  input  logic [4:0]             addrRt_MEM,
  input  logic [4:0]             regWriteAddr_MEM,
  input  logic [31:0]            regWriteData_MEM,
  input  logic [WIDTH_T-1:0]     Tnew_MEM,
  input  logic [4:0]             regaddr_WB,
  input  logic [31:0]            regdata_WB,
  output logic                   dm_req,
  output logic                   dm_we,
  output logic [31:0]            dm_addr,
  output logic [3:0]             dm_be,
  output logic [31:0]            dm_wdata,
  input  logic                   dm_ready,
  input  logic [31:0]            dm_rdata,
  output logic                   MEMBusy,
  output logic [4:0]             regaddr_MEM,
  output logic [31:0]            regdata_MEM,
  output logic [WIDTH_INSTR-1:0] instr_WB,
  output logic [31:0]            PC_WB,
  output logic [4:0]             regWriteAddr_WB,
  output logic [31:0]            regWriteData_WB,
  output logic [WIDTH_T-1:0]     Tnew_WB,
  output logic [$clog2(DM_WAIT_MAX+1)-1:0] dm_wait_cycles
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic                   exc_AdEL,
  output logic                   exc_AdES
`endif
);

  localparam int CW = $clog2(DM_WAIT_MAX + 1);
  localparam logic [CW-1:0] WMAX = CW'(DM_WAIT_MAX);

  function automatic logic [CW-1:0] sat_inc(
    input logic [CW-1:0] v
  );
    return (v >= WMAX) ? WMAX : v + 1'b1;
  endfunction

  func_e       fn;
  logic        is_ld;
  logic        is_st;
  logic        mis;
  logic [1:0]  a;
  logic [31:0] st_data;
  logic [31:0] ldata;

  mem_state_e state_q;
  mem_state_e state_d;
  logic [CW-1:0] cnt_q;

  assign fn    = ic_func(instr_MEM);
  assign is_ld = fn == MEM_READ;
  assign is_st = fn == MEM_WRITE;
  assign a     = aluOut_MEM[1:0];

`ifdef MEM_ALIGN_CHECK_EN
  assign mis = (is_half(instr_MEM) && a[0]) ||
               (is_word(instr_MEM) && a != 2'b00);
`else
  assign mis = 1'b0;
`endif

  // Reset gates the request combinationally so an
  // abandoned access drops in the reset cycle itself.
  assign dm_req  = reset && (is_ld || is_st) && !mis;
  assign dm_we   = dm_req && is_st;
  assign dm_addr = {aluOut_MEM[31:2], 2'b00};
  assign MEMBusy = dm_req && !dm_ready;

  assign st_data =
    (regaddr_WB == addrRt_MEM && regaddr_WB != 5'd0)
      ? regdata_WB : memWriteData_MEM;

  mem_lane u_lane (
    .a       (a),
    .op      (instr_MEM),
    .st_data (st_data),
    .rdata   (dm_rdata),
    .be      (dm_be),
    .wdata   (dm_wdata),
    .ldata   (ldata)
  );

  assign regaddr_MEM = is_ld ? 5'd0 : regWriteAddr_MEM;
  assign regdata_MEM = regWriteData_MEM;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (dm_req && !dm_ready) state_d = WAIT;
      WAIT: if (dm_ready)            state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // cnt_q counts WAIT cycles before the current one, so the
  // completing cycle adds one to give the total stall count.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      dm_wait_cycles <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && state_d == WAIT)
        cnt_q <= '0;
      else if (state_q == WAIT)
        cnt_q <= sat_inc(cnt_q);
      if (dm_req && dm_ready)
        dm_wait_cycles <=
          (state_q == WAIT) ? sat_inc(cnt_q) : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset || MEMBusy) begin
      instr_WB        <= '0;
      PC_WB           <= '0;
      regWriteAddr_WB <= '0;
      regWriteData_WB <= '0;
      Tnew_WB         <= '0;
    end else begin
      instr_WB        <= instr_MEM;
      PC_WB           <= PC_MEM;
      regWriteAddr_WB <= mis ? 5'd0 : regWriteAddr_MEM;
      regWriteData_WB <= is_ld && !mis
                           ? ldata : regWriteData_MEM;
      Tnew_WB         <= (Tnew_MEM == '0)
                           ? '0 : Tnew_MEM - 1'b1;
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (!reset || MEMBusy) begin
      exc_AdEL <= 1'b0;
      exc_AdES <= 1'b0;
    end else begin
      exc_AdEL <= mis && is_ld;
      exc_AdES <= mis && is_st;
    end
  end
`endif

endmodule

// File: tb/tb_mem_level.sv
// Scoreboard bench for mem_level: expected WB bundles queued at drive
// time, popped when the access completes.
module tb_mem_level;
  import mem_level_pkg::*;

  localparam int WMAX = 15;
  localparam int CW = $clog2(WMAX + 1);

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [WIDTH_INSTR-1:0] instr_MEM;
  logic [31:0] PC_MEM, aluOut_MEM, memWriteData_MEM;
  logic [4:0]  addrRt_MEM, regWriteAddr_MEM;
  logic [31:0] regWriteData_MEM;
  logic [WIDTH_T-1:0] Tnew_MEM;
  logic [4:0]  regaddr_WB;
  logic [31:0] regdata_WB;
  logic dm_req, dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_be;
  logic [31:0] dm_wdata;
  logic dm_ready;
  logic [31:0] dm_rdata;
  logic MEMBusy;
  logic [4:0]  regaddr_MEM;
  logic [31:0] regdata_MEM;
  logic [WIDTH_INSTR-1:0] instr_WB;
  logic [31:0] PC_WB;
  logic [4:0]  regWriteAddr_WB;
  logic [31:0] regWriteData_WB;
  logic [WIDTH_T-1:0] Tnew_WB;
  logic [CW-1:0] dm_wait_cycles;
`ifdef MEM_ALIGN_CHECK_EN
  logic exc_AdEL, exc_AdES;
`endif

  typedef struct packed {
    logic [WIDTH_INSTR-1:0] instr;
    logic [31:0]            pc;
    logic [4:0]             rwa;
    logic [31:0]            rwd;
    logic [WIDTH_T-1:0]     tnew;
  } wb_t;

  wb_t sb_q[$];
  int  n_tests = 0;
  int  n_fail = 0;

  always #5 clk = ~clk;

  mem_level #(.DM_WAIT_MAX(WMAX)) dut (
    .clk              (clk),
    .reset            (reset),
    .instr_MEM        (instr_MEM),
    .PC_MEM           (PC_MEM),
    .aluOut_MEM       (aluOut_MEM),
    .memWriteData_MEM (memWriteData_MEM),
    .addrRt_MEM       (addrRt_MEM),
    .regWriteAddr_MEM (regWriteAddr_MEM),
    .regWriteData_MEM (regWriteData_MEM),
    .Tnew_MEM         (Tnew_MEM),
    .regaddr_WB       (regaddr_WB),
    .regdata_WB       (regdata_WB),
    .dm_req           (dm_req),
    .dm_we            (dm_we),
    .dm_addr          (dm_addr),
    .dm_be            (dm_be),
    .dm_wdata         (dm_wdata),
    .dm_ready         (dm_ready),
    .dm_rdata         (dm_rdata),
    .MEMBusy          (MEMBusy),
    .regaddr_MEM      (regaddr_MEM),
    .regdata_MEM      (regdata_MEM),
    .instr_WB         (instr_WB),
    .PC_WB            (PC_WB),
    .regWriteAddr_WB  (regWriteAddr_WB),
    .regWriteData_WB  (regWriteData_WB),
    .Tnew_WB          (Tnew_WB),
    .dm_wait_cycles   (dm_wait_cycles)
`ifdef MEM_ALIGN_CHECK_EN
    ,
    .exc_AdEL         (exc_AdEL),
    .exc_AdES         (exc_AdES)
`endif
  );

  task automatic drive(
    input logic [WIDTH_INSTR-1:0] op,
    input logic [31:0] pc,
    input logic [31:0] addr,
    input logic [31:0] wd,
    input logic [4:0]  rt,
    input logic [4:0]  rwa,
    input logic [31:0] rwd,
    input logic [WIDTH_T-1:0] tn,
    input logic [31:0] rd,
    input logic        rdy
  );
    instr_MEM        = op;
    PC_MEM           = pc;
    aluOut_MEM       = addr;
    memWriteData_MEM = wd;
    addrRt_MEM       = rt;
    regWriteAddr_MEM = rwa;
    regWriteData_MEM = rwd;
    Tnew_MEM         = tn;
    dm_rdata         = rd;
    dm_ready         = rdy;
    regaddr_WB       = 5'd0;
    regdata_WB       = 32'd0;
  endtask

  task automatic exp_push(
    input logic [WIDTH_INSTR-1:0] op,
    input logic [31:0] pc,
    input logic [4:0]  rwa,
    input logic [31:0] rwd,
    input logic [WIDTH_T-1:0] tn
  );
    wb_t e;
    e.instr = op;
    e.pc    = pc;
    e.rwa   = rwa;
    e.rwd   = rwd;
    e.tnew  = (tn == 0) ? '0 : WIDTH_T'(tn - 1);
    sb_q.push_back(e);
  endtask

  // Called #1 after the capturing edge.
  task automatic pop_check(input string name);
    wb_t e, act;
    act = {instr_WB, PC_WB, regWriteAddr_WB,
           regWriteData_WB, Tnew_WB};
    n_tests++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: scoreboard empty, got %h",
               name, act);
    end else begin
      e = sb_q.pop_front();
      if (act !== e) begin
        n_fail++;
        $display("FAIL %s: WB got %h want %h",
                 name, act, e);
      end
    end
  endtask

  task automatic bubble_check(input string name);
    wb_t act;
    act = {instr_WB, PC_WB, regWriteAddr_WB,
           regWriteData_WB, Tnew_WB};
    n_tests++;
    if (act !== '0) begin
      n_fail++;
      $display("FAIL %s: WB got %h want 0", name, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(I_LW, 32'h100, 32'h40, 0, 0, 5'd3,
          0, 2'd1, 32'h1111, 1'b1);
    #4;
    n_tests++;
    if (dm_req !== 1'b0 || MEMBusy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_req: req %b busy %b want 0 0",
               dm_req, MEMBusy);
    end
    step();
    bubble_check("reset_wb");
    n_tests++;
    if (dm_wait_cycles !== '0 || dut.state_q !== IDLE) begin
      n_fail++;
      $display("FAIL reset_state: wait %0d st %0d want 0 0",
               dm_wait_cycles, dut.state_q);
    end
    reset = 1'b1;
  endtask

  task automatic test_store_sb();
    drive(I_SB, 32'h200, 32'h1003, 32'hAB, 5'd2, 5'd0,
          32'h55, 2'd0, 0, 1'b1);
    exp_push(I_SB, 32'h200, 5'd0, 32'h55, 2'd0);
    #4;
    n_tests++;
    if ({dm_req, dm_we, dm_be, dm_addr, dm_wdata, MEMBusy}
        !== {1'b1, 1'b1, 4'b1000, 32'h1000,
             32'hABABABAB, 1'b0}) begin
      n_fail++;
      $display("FAIL sb_port: req%b we%b be%b a%h d%h b%b",
               dm_req, dm_we, dm_be, dm_addr, dm_wdata,
               MEMBusy);
    end
    step();
    pop_check("sb_wb");
  endtask

  task automatic test_load_ext();
    logic [WIDTH_INSTR-1:0] ops[6];
    logic [31:0] ad[6], rd[6], res[6];
    ops = '{I_LB, I_LBU, I_LH, I_LHU, I_LW, I_SH};
    ad  = '{32'h2001, 32'h2001, 32'h2002, 32'h2002,
            32'h2004, 32'h2002};
    rd  = '{32'h123480FF, 32'h123480FF, 32'h80FF1234,
            32'h80FF1234, 32'h89ABCDEF, 32'h0};
    res = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF,
            32'h000080FF, 32'h89ABCDEF, 32'h77};
    for (int i = 0; i < 6; i++) begin
      drive(ops[i], 32'h300 + i, ad[i], 32'h0000BEEF,
            5'd4, 5'd9, 32'h77, 2'd3, rd[i], 1'b1);
      exp_push(ops[i], 32'h300 + i,
               (ops[i] == I_SH) ? 5'd9 : 5'd9,
               res[i], 2'd3);
      #4;
      if (ops[i] == I_SH) begin
        n_tests++;
        if ({dm_be, dm_wdata} !== {4'b1100, 32'hBEEFBEEF}) begin
          n_fail++;
          $display("FAIL sh_port: be %b d %h want 1100 beefbeef",
                   dm_be, dm_wdata);
        end
      end else begin
        n_tests++;
        if ({regaddr_MEM, dm_be, dm_we} !== {5'd0, 4'b1111, 1'b0}) begin
          n_fail++;
          $display("FAIL ld_port%0d: ra %0d be %b we %b",
                   i, regaddr_MEM, dm_be, dm_we);
        end
      end
      step();
      pop_check("load_wb");
    end
  endtask

  task automatic test_forward();
    drive(I_SW, 32'h400, 32'h500, 32'h11112222, 5'd5,
          5'd0, 0, 2'd1, 0, 1'b1);
    regaddr_WB = 5'd5;
    regdata_WB = 32'hDEADBEEF;
    exp_push(I_SW, 32'h400, 5'd0, 0, 2'd1);
    #4;
    n_tests++;
    if ({dm_wdata, dm_be} !== {32'hDEADBEEF, 4'b1111}) begin
      n_fail++;
      $display("FAIL fwd_hit: d %h be %b want deadbeef 1111",
               dm_wdata, dm_be);
    end
    step();
    pop_check("fwd_wb");
    drive(I_SW, 32'h404, 32'h500, 32'h11112222, 5'd5,
          5'd0, 0, 2'd1, 0, 1'b1);
    regdata_WB = 32'hDEADBEEF;
    #4;
    n_tests++;
    if (dm_wdata !== 32'h11112222) begin
      n_fail++;
      $display("FAIL fwd_zero: d %h want 11112222", dm_wdata);
    end
    addrRt_MEM = 5'd0;
    #1;
    n_tests++;
    if (dm_wdata !== 32'h11112222) begin
      n_fail++;
      $display("FAIL fwd_r0: d %h want 11112222", dm_wdata);
    end
    exp_push(I_SW, 32'h404, 5'd0, 0, 2'd1);
    step();
    pop_check("fwd_wb2");
  endtask

  task automatic test_wait(input int nw, input string name);
    int ew;
    drive(I_LW, 32'h600, 32'h4000, 0, 5'd0, 5'd7,
          0, 2'd2, 32'hCAFEF00D, 1'b0);
    exp_push(I_LW, 32'h600, 5'd7, 32'hCAFEF00D, 2'd2);
    for (int i = 0; i < nw; i++) begin
      #4;
      n_tests++;
      if ({MEMBusy, dm_req, dm_addr} !== {1'b1, 1'b1, 32'h4000}) begin
        n_fail++;
        $display("FAIL %s_busy%0d: busy %b req %b a %h",
                 name, i, MEMBusy, dm_req, dm_addr);
      end
      step();
      bubble_check({name, "_bubble"});
    end
    dm_ready = 1'b1;
    #4;
    n_tests++;
    if (MEMBusy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_done: busy %b want 0", name, MEMBusy);
    end
    step();
    pop_check({name, "_wb"});
    ew = (nw > WMAX) ? WMAX : nw;
    n_tests++;
    if (dm_wait_cycles !== CW'(ew)) begin
      n_fail++;
      $display("FAIL %s_cnt: got %0d want %0d",
               name, dm_wait_cycles, ew);
    end
  endtask

  task automatic test_alu();
    drive(I_ADDU, 32'h700, 32'h3, 0, 5'd0, 5'd12,
          32'h12345678, 2'd0, 0, 1'b1);
    exp_push(I_ADDU, 32'h700, 5'd12, 32'h12345678, 2'd0);
    #4;
    n_tests++;
    if ({dm_req, MEMBusy, regaddr_MEM, regdata_MEM}
        !== {1'b0, 1'b0, 5'd12, 32'h12345678}) begin
      n_fail++;
      $display("FAIL alu_port: req %b busy %b ra %0d rd %h",
               dm_req, MEMBusy, regaddr_MEM, regdata_MEM);
    end
    step();
    pop_check("alu_wb");
    n_tests++;
    if (dut.state_q !== IDLE || dm_wait_cycles !== CW'(3)) begin
      n_fail++;
      $display("FAIL alu_ignore: st %0d wait %0d want 0 3",
               dut.state_q, dm_wait_cycles);
    end
  endtask

  task automatic test_reset_wait();
    drive(I_LW, 32'h800, 32'h8000, 0, 5'd0, 5'd8,
          0, 2'd1, 32'h1, 1'b0);
    #4;
    step();
    bubble_check("rstw_bubble");
    reset = 1'b0;
    #4;
    n_tests++;
    if ({dm_req, MEMBusy} !== 2'b00) begin
      n_fail++;
      $display("FAIL rstw_req: req %b busy %b want 0 0",
               dm_req, MEMBusy);
    end
    step();
    bubble_check("rstw_wb");
    n_tests++;
    if (dut.state_q !== IDLE || dm_wait_cycles !== '0) begin
      n_fail++;
      $display("FAIL rstw_state: st %0d wait %0d want 0 0",
               dut.state_q, dm_wait_cycles);
    end
    reset = 1'b1;
    drive(I_LW, 32'h810, 32'h8000, 0, 5'd0, 5'd8,
          0, 2'd1, 32'h0BADF00D, 1'b1);
    exp_push(I_LW, 32'h810, 5'd8, 32'h0BADF00D, 2'd1);
    step();
    pop_check("rstw_next");
  endtask

  task automatic test_align();
    drive(I_LH, 32'h900, 32'h3001, 0, 5'd0, 5'd6,
          32'h99, 2'd1, 32'hAAAA8001, 1'b1);
`ifdef MEM_ALIGN_CHECK_EN
    exp_push(I_LH, 32'h900, 5'd0, 32'h99, 2'd1);
    #4;
    n_tests++;
    if (dm_req !== 1'b0) begin
      n_fail++;
      $display("FAIL align_req: req %b want 0", dm_req);
    end
    step();
    pop_check("align_wb");
    n_tests++;
    if ({exc_AdEL, exc_AdES} !== 2'b10) begin
      n_fail++;
      $display("FAIL align_exc: %b%b want 10",
               exc_AdEL, exc_AdES);
    end
`else
    exp_push(I_LH, 32'h900, 5'd6, 32'hFFFF8001, 2'd1);
    #4;
    n_tests++;
    if ({dm_req, dm_addr, dm_be} !== {1'b1, 32'h3000, 4'b1111}) begin
      n_fail++;
      $display("FAIL align_port: req %b a %h be %b",
               dm_req, dm_addr, dm_be);
    end
    step();
    pop_check("align_wb");
`endif
  endtask

  task automatic test_back_to_back();
    drive(I_SB, 32'hA00, 32'h10, 32'h5A, 5'd0, 5'd0,
          32'h1, 2'd2, 0, 1'b1);
    exp_push(I_SB, 32'hA00, 5'd0, 32'h1, 2'd2);
    #4;
    n_tests++;
    if ({dm_be, dm_wdata} !== {4'b0001, 32'h5A5A5A5A}) begin
      n_fail++;
      $display("FAIL b2b_sb: be %b d %h", dm_be, dm_wdata);
    end
    step();
    drive(I_LBU, 32'hA04, 32'h12, 0, 5'd0, 5'd3,
          0, 2'd2, 32'h00C30000, 1'b1);
    exp_push(I_LBU, 32'hA04, 5'd3, 32'h000000C3, 2'd2);
    pop_check("b2b_wb1");
    step();
    pop_check("b2b_wb2");
  endtask

  initial begin
    drive(I_NOP, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0);
    step();
    test_reset();
    test_store_sb();
    test_load_ext();
    test_forward();
    test_wait(3, "wait3");
    test_alu();
    test_wait(17, "wait_sat");
    test_reset_wait();
    test_align();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
